// File: rtl/switch_ingress_arbiter.sv
// Packet-granular round-robin arbiter sharing the switch source port between
// NUM_REQ requesters, with a registered output beat and a mid-packet watchdog.
module switch_ingress_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        sw_stall,
  output logic                        sw_src_valid,
  output logic [ADDR_W-1:0]           sw_src_addr,
  output logic [DATA_W-1:0]           sw_src_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        abort
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    grant_id_q;
  logic [CW-1:0]     idle_cnt_q;
  logic              busy_q;
  logic              abort_q;
  logic              src_valid_q;
  logic [ADDR_W-1:0] src_addr_q;
  logic [DATA_W-1:0] src_data_q;

  logic              found;
  logic [IDW-1:0]    pick;
  logic              own_valid;
  logic              own_last;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;
  logic              accept;
  logic              idle_cyc;
  logic [IDW-1:0]    rr_next;

  // First valid requester scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_data  = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IDW'(k) == grant_id_q) begin
        own_valid    = req_valid[k];
        own_last     = req_last[k];
        own_addr     = req_addr[k*ADDR_W +: ADDR_W];
        own_data     = req_data[k*DATA_W +: DATA_W];
        req_ready[k] = (state_q == GRANT) && !sw_stall && !reset;
      end
    end
  end

  assign accept   = (state_q == GRANT) && own_valid && !sw_stall;
  assign idle_cyc = (state_q == GRANT) && !own_valid && !sw_stall;
  assign rr_next  = (32'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      idle_cnt_q  <= '0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      src_valid_q <= 1'b0;
      src_addr_q  <= '0;
      src_data_q  <= '0;
    end else begin
      abort_q     <= 1'b0;
      src_valid_q <= 1'b0;
      src_addr_q  <= '0;
      src_data_q  <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_id_q <= pick;
            busy_q     <= 1'b1;
            idle_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            src_valid_q <= 1'b1;
            src_addr_q  <= own_addr;
            src_data_q  <= own_data;
            idle_cnt_q  <= '0;
            if (own_last) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              rr_ptr_q <= rr_next;
            end
          end else if (idle_cyc) begin
            // Stall cycles fall through here untouched, so the count only
            // measures cycles where the owner itself is silent.
            if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              abort_q    <= 1'b1;
              rr_ptr_q   <= rr_next;
              idle_cnt_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw_src_valid = src_valid_q;
  assign sw_src_addr  = src_addr_q;
  assign sw_src_data  = src_data_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign abort        = abort_q;

endmodule

// File: tb/tb_switch_ingress_arbiter.sv
// Directed bench for switch_ingress_arbiter: vector table for arbitration,
// round-robin and stall behaviour, hand sequences for watchdog and reset.
module tb_switch_ingress_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        sw_stall;
  logic        sw_src_valid;
  logic [7:0]  sw_src_addr;
  logic [7:0]  sw_src_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        abort;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_ingress_arbiter #(
    .NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .sw_stall(sw_stall), .sw_src_valid(sw_src_valid), .sw_src_addr(sw_src_addr),
    .sw_src_data(sw_src_data), .grant_id(grant_id), .busy(busy), .abort(abort)
  );

  typedef struct {
    logic [3:0] vld;
    logic [3:0] lst;
    logic       stl;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       ev;
    logic [7:0] ea;
    logic [7:0] ed;
    logic       eb;
    logic [1:0] eg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] vld, logic [3:0] lst, logic stl,
                              logic [7:0] d, logic [3:0] rdy, logic ev,
                              logic [7:0] ea, logic [7:0] ed, logic eb,
                              logic [1:0] eg);
    vec_t v;
    v.vld = vld; v.lst = lst; v.stl = stl; v.d = d; v.rdy = rdy;
    v.ev = ev; v.ea = ea; v.ed = ed; v.eb = eb; v.eg = eg;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(string tag, logic ev, logic [7:0] ea, logic [7:0] ed,
                         logic eb, logic [1:0] eg, logic eab);
    chk({tag, ".valid"}, int'(sw_src_valid), int'(ev));
    chk({tag, ".addr"},  int'(sw_src_addr),  int'(ea));
    chk({tag, ".data"},  int'(sw_src_data),  int'(ed));
    chk({tag, ".busy"},  int'(busy),         int'(eb));
    chk({tag, ".abort"}, int'(abort),        int'(eab));
    if (eb) chk({tag, ".grant"}, int'(grant_id), int'(eg));
  endtask

  task automatic drive(logic [3:0] vld, logic [3:0] lst, logic stl, logic [7:0] d);
    req_valid = vld;
    req_last  = lst;
    sw_stall  = stl;
    req_data  = {4{d}};
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset    = 1'b1;
    for (int i = 0; i < 4; i++) req_addr[i*8 +: 8] = 8'(3 + i);
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    step();
    step();
    chk_out("reset", 1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
    chk("reset.grant", int'(grant_id), 0);
    chk("reset.ready", int'(req_ready), 0);
    reset = 1'b0;

    // 3-beat packet from requester 2, then all four contending with 1-beat
    // packets (starting at requester 3 since rr_ptr=3), then a stalled packet.
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 8'hA1, 4'b0000, 0, 8'h00, 8'h00, 1, 2));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 8'hA1, 4'b0100, 1, 8'h05, 8'hA1, 1, 2));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 8'hA2, 4'b0100, 1, 8'h05, 8'hA2, 1, 2));
    tbl.push_back(mk(4'b0100, 4'b0100, 0, 8'hA3, 4'b0100, 1, 8'h05, 8'hA3, 0, 2));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 8'h00, 8'h00, 0, 2));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB0, 4'b0000, 0, 8'h00, 8'h00, 1, 3));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB0, 4'b1000, 1, 8'h06, 8'hB0, 0, 3));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB1, 4'b0000, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB1, 4'b0001, 1, 8'h03, 8'hB1, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB2, 4'b0000, 0, 8'h00, 8'h00, 1, 1));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB2, 4'b0010, 1, 8'h04, 8'hB2, 0, 1));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB3, 4'b0000, 0, 8'h00, 8'h00, 1, 2));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB3, 4'b0100, 1, 8'h05, 8'hB3, 0, 2));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB4, 4'b0000, 0, 8'h00, 8'h00, 1, 3));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB4, 4'b1000, 1, 8'h06, 8'hB4, 0, 3));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB5, 4'b0000, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b1111, 0, 8'hB5, 4'b0001, 1, 8'h03, 8'hB5, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(4'b0010, 4'b0000, 0, 8'hC1, 4'b0000, 0, 8'h00, 8'h00, 1, 1));
    tbl.push_back(mk(4'b0010, 4'b0000, 0, 8'hC1, 4'b0010, 1, 8'h04, 8'hC1, 1, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(4'b0010, 4'b0000, 1, 8'hC2, 4'b0000, 0, 8'h00, 8'h00, 1, 1));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 8'hC2, 4'b0010, 1, 8'h04, 8'hC2, 0, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 8'h00, 8'h00, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].lst, tbl[i].stl, tbl[i].d);
      #1;
      chk($sformatf("vec%0d.ready", i), int'(req_ready), int'(tbl[i].rdy));
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].ed,
              tbl[i].eb, tbl[i].eg, 1'b0);
    end

    // Watchdog: requester 0 goes silent after beat 1 while requester 3 waits.
    drive(4'b0001, 4'b0000, 1'b0, 8'hD1);
    step();
    chk_out("to_arb", 1'b0, 8'h00, 8'h00, 1'b1, 2'd0, 1'b0);
    step();
    chk_out("to_beat1", 1'b1, 8'h03, 8'hD1, 1'b1, 2'd0, 1'b0);
    drive(4'b1000, 4'b0000, 1'b0, 8'hD2);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk_out($sformatf("to_idle%0d", i), 1'b0, 8'h00, 8'h00, 1'b1, 2'd0, 1'b0);
    end
    step();
    chk_out("to_abort", 1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1);
    step();
    chk_out("to_next", 1'b0, 8'h00, 8'h00, 1'b1, 2'd3, 1'b0);
    drive(4'b1000, 4'b1000, 1'b0, 8'hD3);
    step();
    chk_out("to_g3", 1'b1, 8'h06, 8'hD3, 1'b0, 2'd3, 1'b0);

    // Beat returns on the 16th idle slot: accepted, no abort.
    drive(4'b0001, 4'b0000, 1'b0, 8'hE1);
    step();
    chk_out("tv_arb", 1'b0, 8'h00, 8'h00, 1'b1, 2'd0, 1'b0);
    step();
    chk_out("tv_beat1", 1'b1, 8'h03, 8'hE1, 1'b1, 2'd0, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk_out($sformatf("tv_idle%0d", i), 1'b0, 8'h00, 8'h00, 1'b1, 2'd0, 1'b0);
    end
    drive(4'b0001, 4'b0001, 1'b0, 8'hE2);
    step();
    chk_out("tv_late", 1'b1, 8'h03, 8'hE2, 1'b0, 2'd0, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    step();
    chk_out("tv_after", 1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);

    // Reset mid-packet (owner 2, beat 2), then rr_ptr restarts at 0.
    drive(4'b0100, 4'b0000, 1'b0, 8'hF1);
    step();
    chk_out("rst_arb", 1'b0, 8'h00, 8'h00, 1'b1, 2'd2, 1'b0);
    step();
    chk_out("rst_beat1", 1'b1, 8'h05, 8'hF1, 1'b1, 2'd2, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0, 8'hF2);
    reset = 1'b1;
    #1;
    chk("rst_ready_in", int'(req_ready), 0);
    step();
    chk_out("rst_mid", 1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
    chk("rst_mid.grant", int'(grant_id), 0);
    reset = 1'b0;
    drive(4'b0110, 4'b0000, 1'b0, 8'hF3);
    #1;
    chk("rst_ready_out", int'(req_ready), 0);
    step();
    chk_out("rst_rr", 1'b0, 8'h00, 8'h00, 1'b1, 2'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
